// File: rtl/cpu_pkg.sv
// Shared CPU types: RAM handshake, instruction-memory bundle, and the
// memory-arbiter state and grant encodings.
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef struct packed {
    logic  valid;
    word_t data;
  } imem_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IACC,
    ARB_DACC,
    ARB_RESP
  } arbstate_t;

  typedef enum logic {
    GNT_INSTR,
    GNT_DATA
  } grant_t;

  localparam int ARB_TIMEOUT = 64;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and load/store,
// one access at a time, with alternating priority and an access timeout.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output imem_t             i_data,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  word_t             d_wdata,
  input  logic [3:0]        d_sel,
  output logic              d_ack,
  output word_t             d_rdata,
  output logic              err,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output word_t             ram_wdata,
  output logic [3:0]        ram_sel,
  input  ramstate_t         ram_state,
  input  word_t             ram_rdata
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arbstate_t         state_q, state_d;
  grant_t            grant_q, last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              ren_q, wen_q;
  logic [ADDR_W-1:0] addr_q;
  word_t             wdata_q;
  logic [3:0]        sel_q;
  word_t             idata_q, drdata_q;

  logic d_req, pick_data, acc_done, acc_fail;

  // Data wins unless fetch is also waiting and data had the previous grant.
  assign d_req     = d_ren | d_wen;
  assign pick_data = d_req & (~i_req | (last_grant_q == GNT_INSTR));
  assign acc_done  = (ram_state == RAM_ACCESS);
  assign acc_fail  = (ram_state == RAM_ERROR) | (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_data)  state_d = ARB_DACC;
        else if (i_req) state_d = ARB_IACC;
      end
      ARB_IACC, ARB_DACC: begin
        if (acc_done || acc_fail) state_d = ARB_RESP;
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Command latch on grant, response capture at the end of the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= GNT_INSTR;
      last_grant_q <= GNT_INSTR;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      idata_q      <= '0;
      drdata_q     <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
          if (pick_data) begin
            grant_q <= GNT_DATA;
            ren_q   <= d_ren & ~d_wen;
            wen_q   <= d_wen;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            sel_q   <= d_sel;
          end else if (i_req) begin
            grant_q <= GNT_INSTR;
            ren_q   <= 1'b1;
            wen_q   <= 1'b0;
            addr_q  <= i_addr;
            wdata_q <= '0;
            sel_q   <= 4'hF;
          end
        end
        ARB_IACC, ARB_DACC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (acc_done || acc_fail) begin
            err_q <= ~acc_done;
            if (grant_q == GNT_DATA) drdata_q <= acc_done ? ram_rdata : '0;
            else                     idata_q  <= acc_done ? ram_rdata : '0;
          end
        end
        ARB_RESP: begin
          last_grant_q <= grant_q;
          cnt_q        <= '0;
          err_q        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_ren = 1'b0;
    ram_wen = 1'b0;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    err     = 1'b0;
    if (state_q == ARB_IACC || state_q == ARB_DACC) begin
      ram_ren = ren_q;
      ram_wen = wen_q;
    end
    if (state_q == ARB_RESP) begin
      i_ack = (grant_q == GNT_INSTR);
      d_ack = (grant_q == GNT_DATA);
      err   = err_q;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_sel   = sel_q;
  assign i_data    = {i_ack, idata_q};
  assign d_rdata   = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of arbitration and RAM replies.
module tb_mem_arbiter;
  import cpu_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  imem_t             i_data;
  logic              d_ren, d_wen;
  logic [ADDR_W-1:0] d_addr;
  word_t             d_wdata;
  logic [3:0]        d_sel;
  logic              d_ack;
  word_t             d_rdata;
  logic              err;
  logic              ram_ren, ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  word_t             ram_wdata;
  logic [3:0]        ram_sel;
  ramstate_t         ram_state;
  word_t             ram_rdata;

  int    n_chk  = 0;
  int    n_fail = 0;
  bit    m_last_data;
  word_t exp_i, exp_d;
  bit    w;
  logic [1:0] op;

  mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sel(d_sel), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_sel(ram_sel),
    .ram_state(ram_state), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_quiet"}, {ram_ren, ram_wen, i_ack, d_ack, err, i_data.valid}, 0);
    chk({tag, "_i_hold"}, i_data.data, exp_i);
    chk({tag, "_d_hold"}, d_rdata, exp_d);
  endtask

  // Entered at the negedge of an idle cycle with requests already driven.
  // k: cycle of the RAM's final answer (ACCESS, or ERROR if use_err).
  task automatic txn(input int k, input bit use_err, input word_t rd, output bit won_d);
    logic [ADDR_W-1:0] e_addr;
    logic              e_ren, e_wen;
    word_t             e_wd;
    logic [3:0]        e_sel;
    int                last;
    bit                e_err;
    won_d = 1'b0;
    if (!i_req && !(d_ren || d_wen)) begin
      @(negedge clk);
      idle_chk("no_req");
      return;
    end
    won_d = (d_ren || d_wen) && (!i_req || !m_last_data);
    if (won_d) begin
      e_addr = d_addr; e_wen = d_wen; e_ren = d_ren && !d_wen; e_wd = d_wdata; e_sel = d_sel;
    end else begin
      e_addr = i_addr; e_wen = 1'b0; e_ren = 1'b1; e_wd = '0; e_sel = 4'hF;
    end
    last  = (k <= TIMEOUT) ? k : TIMEOUT;
    e_err = (k <= TIMEOUT) ? use_err : 1'b1;
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      if (j == 1) begin
        if (won_d) begin d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom); end
        else i_addr = $urandom;
      end
      if (j == 2 && $urandom_range(0, 7) == 0) begin
        if (won_d) begin d_ren = 1'b0; d_wen = 1'b0; end
        else i_req = 1'b0;
      end
      chk("ram_ren", ram_ren, e_ren);
      chk("ram_wen", ram_wen, e_wen);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_sel", ram_sel, e_sel);
      if (won_d) chk("ram_wdata", ram_wdata, e_wd);
      chk("ack_during_access", {i_ack, d_ack, err}, 0);
      if (j == k) begin
        ram_state = use_err ? RAM_ERROR : RAM_ACCESS;
        ram_rdata = rd;
      end else begin
        ram_state = $urandom_range(0, 1) ? RAM_BUSY : RAM_FREE;
        ram_rdata = $urandom;
      end
    end
    @(negedge clk);
    ram_state = RAM_FREE;
    ram_rdata = $urandom;
    if (won_d) exp_d = e_err ? '0 : rd;
    else       exp_i = e_err ? '0 : rd;
    chk("resp_strobes", {ram_ren, ram_wen}, 0);
    chk("i_ack", i_ack, !won_d);
    chk("i_valid", i_data.valid, !won_d);
    chk("d_ack", d_ack, won_d);
    chk("err", err, e_err);
    chk("i_data", i_data.data, exp_i);
    chk("d_rdata", d_rdata, exp_d);
    m_last_data = won_d;
    if (won_d) begin d_ren = 1'b0; d_wen = 1'b0; end
    else i_req = 1'b0;
    @(negedge clk);
    idle_chk("after_resp");
  endtask

  task automatic all_zero_chk(input string tag);
    idle_chk(tag);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_sel"}, ram_sel, 0);
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0; d_sel = '0; ram_state = RAM_FREE; ram_rdata = '0;
    m_last_data = 1'b0; exp_i = '0; exp_d = '0;
    repeat (3) @(negedge clk);
    all_zero_chk("reset");
    rst = 1'b0;

    // Contention straight out of reset: data, instr, data, instr.
    for (int n = 0; n < 4; n++) begin
      i_req = 1'b1; i_addr = $urandom; d_ren = 1'b1; d_wen = 1'b0;
      d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom);
      txn(2, 1'b0, $urandom, w);
      chk("contention_grant", w, (n % 2 == 0));
    end
    i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;

    // Fetch with three wait cycles.
    i_req = 1'b1; i_addr = 32'h100;
    txn(4, 1'b0, 32'hDEADBEEF, w);
    chk("fetch_grant", w, 0);
    chk("fetch_data_hold", i_data.data, 32'hDEADBEEF);

    // Store with one wait cycle.
    d_wen = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_sel = 4'b0011;
    txn(2, 1'b0, $urandom, w);
    chk("store_grant", w, 1);

    // RAM error on a load, then a clean fetch.
    d_ren = 1'b1; d_addr = 32'h40;
    txn(3, 1'b1, 32'hCAFEF00D, w);
    chk("err_rdata_zero", d_rdata, 0);
    i_req = 1'b1; i_addr = 32'h104;
    txn(1, 1'b0, 32'h0BADF00D, w);
    chk("fetch_after_err", i_data.data, 32'h0BADF00D);

    // RAM stuck busy: abort after TIMEOUT cycles.
    i_req = 1'b1; i_addr = 32'h108;
    txn(TIMEOUT + 5, 1'b0, $urandom, w);
    chk("timeout_data_zero", i_data.data, 0);

    // Reset in the middle of a fetch.
    i_req = 1'b1; i_addr = 32'h300; ram_state = RAM_BUSY;
    @(negedge clk);
    chk("pre_reset_ren", ram_ren, 1);
    rst = 1'b1;
    @(negedge clk);
    exp_i = '0; exp_d = '0; m_last_data = 1'b0;
    all_zero_chk("mid_reset");
    rst = 1'b0; i_req = 1'b0; ram_state = RAM_FREE;
    @(negedge clk);
    idle_chk("post_reset");
    i_req = 1'b1; i_addr = 32'h300;
    txn(2, 1'b0, 32'h55AA55AA, w);
    chk("refetch_after_reset", i_data.data, 32'h55AA55AA);

    // Random traffic; a losing requester keeps its request pending.
    for (int n = 0; n < 200; n++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!(d_ren || d_wen) && $urandom_range(0, 1) == 1) begin
        op = 2'($urandom_range(1, 3));
        d_ren = op[0]; d_wen = op[1];
        d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom);
      end
      txn($urandom_range(1, TIMEOUT + 2), $urandom_range(0, 5) == 0, $urandom, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-ported RAM between the instruction-fetch path and the load/store path of the CPU. It accepts one request at a time, drives the RAM command lines, and tracks the RAM through its ramstate_t handshake (FREE/BUSY/ACCESS/ERROR). It returns read data, or write completion, to the winning requester with a one-cycle acknowledge. It sits between the fetch/memory stages and the RAM model, and replaces the direct RAM hookup.

Parameters:
ADDR_W, 32, address width in bits, matching WORD_W.
TIMEOUT, 64, maximum cycles an access may stay un-ACCESSed before it is aborted as an error (>=2).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request (level, held until i_ack)
i_addr  in  ADDR_W  fetch address
i_ack  out  1  one-cycle pulse, fetch complete
i_data  out  33  imem_t {valid, data}; valid pulses with i_ack
d_ren  in  1  load request (level, held until d_ack)
d_wen  in  1  store request (level, held until d_ack)
d_addr  in  ADDR_W  load/store address
d_wdata  in  32  store data
d_sel  in  4  byte enables
d_ack  out  1  one-cycle pulse, load/store complete
d_rdata  out  32  load data, valid when d_ack
err  out  1  one-cycle pulse with the ack of an aborted access
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  32  RAM write data
ram_sel  out  4  RAM byte enables
ram_state  in  2  ramstate_t from the RAM
ram_rdata  in  32  RAM read data, valid while ram_state==ACCESS

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, last_grant=INSTR, timeout counter 0, every output 0 (including i_data.valid and the data buses).
- A reset mid-access abandons the access. Strobes drop on the next edge, no ack is issued, and requesters must re-request.
- FSM states: IDLE, IACC, DACC, RESP.
- IDLE:
  - If there is a data request (d_ren|d_wen) and either no i_req or last_grant==INSTR, go to DACC.
  - Otherwise, if i_req, go to IACC.
  - Otherwise, stay in IDLE.
  - This alternates on contention, with data winning the first tie after reset, so neither requester starves.
  - Command outputs are registered on the IDLE->xACC edge: address, wdata, sel and the strobe are latched. They are held stable and unchanged until the access ends.
- Command encoding:
  - IACC: ram_ren=1, ram_wen=0, ram_sel=4'hF.
  - DACC: ram_wen=d_wen, ram_ren=d_ren&~d_wen. A store wins if both are asserted.
- In IACC/DACC, with the timeout counter incrementing each cycle:
  - ram_state==ACCESS: capture ram_rdata, drop strobes, go to RESP.
  - ram_state==ERROR, or counter==TIMEOUT-1: drop strobes, set the error flag, go to RESP.
  - FREE or BUSY: stay.
- RESP (exactly one cycle):
  - Pulse i_ack (with i_data.valid=1) or d_ack, per the grant. Present the captured data; err=1 if the error flag is set.
  - Read data on error is 0.
  - Update last_grant, clear the counter and error flag, go to IDLE.
- Latency: request sampled in IDLE at cycle 0; strobe visible at cycle 1; RAM ACCESS at cycle k; ack at cycle k+1. The minimum request-to-ack time is 2 cycles, and the next grant's strobe appears no earlier than 2 cycles after ack.
- Requests deasserted mid-access are ignored; the access completes and acks anyway.
- i_data.data and d_rdata hold their last value between acks. Valid is only meaningful with the ack.

Decomposition:
- Shared package (cpu_pkg) gains:
  - arbstate_t enum {ARB_IDLE, ARB_IACC, ARB_DACC, ARB_RESP}
  - grant_t enum {GNT_INSTR, GNT_DATA}
  - ARB_TIMEOUT default constant.
- ramstate_t, imem_t and word_t are reused from cpu_pkg.
- Sub-module: none required. The timeout counter is inline.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100; RAM answers BUSY for 3 cycles then ACCESS with 0xDEADBEEF -> ram_ren=1 / ram_addr=0x100 from cycle 1; i_ack with i_data={1,0xDEADBEEF} at cycle 5; no d_ack.
- Store: d_wen=1, d_addr=0x200, d_wdata=0x12345678, d_sel=4'b0011; RAM ACCESS at cycle 2 -> ram_wen=1 and ram_ren=0 with fields latched; d_ack at cycle 3; err=0.
- Contention: i_req and d_ren both asserted from reset and held, RAM always answering after 1 BUSY -> grants are DATA, INSTR, DATA, INSTR; each ack is a single cycle.
- Error: RAM returns ERROR during DACC -> d_ack and err pulse together, d_rdata=0, FSM back in IDLE; a following fetch succeeds normally.
- Timeout: TIMEOUT=8, RAM stuck BUSY -> strobe drops after 8 cycles in IACC; i_ack and err pulse the next cycle.
- Reset mid-access: assert rst during IACC with the RAM BUSY -> next cycle all outputs 0, no i_ack; a fresh request after reset completes.
